// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: sync, data-enable, coordinates and line/frame strobes.
// Optional colour-bar test pattern on rgb_o when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic [23:0]      rgb_o
);

    localparam int unsigned HTotal = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int unsigned VTotal = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [CNT_W-1:0] HLast     = CNT_W'(HTotal - 1);
    localparam logic [CNT_W-1:0] VLast     = CNT_W'(VTotal - 1);
    localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HActStart = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HActEnd   = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [CNT_W-1:0] VActStart = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VActEnd   = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap, v_wrap, hact, vact;

    always_comb begin
        h_wrap  = (h_cnt_q == HLast);
        v_wrap  = (v_cnt_q == VLast);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
        end

        // Outputs decode the current count; they appear one ce-cycle later.
        hact          = (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd);
        vact          = (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
        de_d          = hact & vact;
        x_d           = de_d ? (h_cnt_q - HActStart) : '0;
        y_d           = de_d ? (v_cnt_q - VActStart) : '0;
        hsync_d       = (h_cnt_q < HSyncEnd) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (v_cnt_q < VSyncEnd) ? VSYNC_POL : ~VSYNC_POL;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (ce_i) begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BarW = ((H_VISIBLE / 8) == 0) ? 1 : (H_VISIBLE / 8);

    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar;
    logic [23:0]      rgb_q, rgb_d;

    // Bar is derived from x_d so rgb lands in the same cycle as de/x/y.
    always_comb begin
        bar_idx = x_d / CNT_W'(BarW);
        bar     = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];
        unique case (bar)
            3'd0:    rgb_d = 24'hFFFFFF;
            3'd1:    rgb_d = 24'hFFFF00;
            3'd2:    rgb_d = 24'h00FFFF;
            3'd3:    rgb_d = 24'h00FF00;
            3'd4:    rgb_d = 24'hFF00FF;
            3'd5:    rgb_d = 24'hFF0000;
            3'd6:    rgb_d = 24'h0000FF;
            default: rgb_d = 24'h000000;
        endcase
        if (!de_d) begin
            rgb_d = 24'h000000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q <= '0;
        end else if (ce_i) begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;
`else
    assign rgb_o = 24'h000000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 23x8 raster (16x4 visible) so full frames stay short.
// Expected values are hand-derived from the chosen timing; rgb expectations follow VGA_TEST_PATTERN_EN.
module tb_vga_timing_gen;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] x, y;
    logic [23:0]   rgb;

    int checks   = 0;
    int failures = 0;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [23:0] RgbX0  = 24'hFFFFFF;
    localparam logic [23:0] RgbX2  = 24'hFFFF00;
    localparam logic [23:0] RgbX4  = 24'h00FFFF;
    localparam logic [23:0] RgbX15 = 24'h000000;
`else
    localparam logic [23:0] RgbX0  = 24'h000000;
    localparam logic [23:0] RgbX2  = 24'h000000;
    localparam logic [23:0] RgbX4  = 24'h000000;
    localparam logic [23:0] RgbX15 = 24'h000000;
`endif

    // H: sync 3, back 2, visible 16, front 2 -> 23. V: sync 2, back 1, visible 4, front 1 -> 8.
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CNT_W(CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ce_i         (ce),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .de_o         (de),
        .x_o          (x),
        .y_o          (y),
        .line_start_o (line_start),
        .frame_start_o(frame_start),
        .rgb_o        (rgb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_xy"}, {x, y}, 0);
        check({tag, "_strobes"}, {line_start, frame_start}, 0);
        check({tag, "_rgb"}, rgb, 0);
    endtask

    int n_ls, n_fs, n_hs, n_vs, n_de, n_blank_bad;
    int hold_bad, ls_rises, fs_rise0, fs_rise1;
    logic [44:0] snap, prev;

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");

        // Free-running frame walk: after the k-th ce edge outputs decode position p = k-1.
        rst = 1'b0;
        ce  = 1'b1;
        n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_de = 0; n_blank_bad = 0;
        for (int p = 0; p <= 184; p++) begin
            tick();
            if (p < 184) begin
                n_ls += int'(line_start);
                n_fs += int'(frame_start);
                n_hs += int'(hsync == 1'b0);
                n_vs += int'(vsync == 1'b1);
                n_de += int'(de);
                if (!de && (x != 0 || y != 0 || rgb != 0)) n_blank_bad++;
            end
            case (p)
                0: begin
                    check("p0_strobes", {frame_start, line_start}, 2'b11);
                    check("p0_sync", {hsync, vsync}, 2'b01);
                    check("p0_de", de, 0);
                end
                1:   check("p1_strobes", {frame_start, line_start}, 2'b00);
                2:   check("p2_hsync_active", hsync, 0);
                3:   check("p3_hsync_idle", hsync, 1);
                45:  check("p45_vsync_active", vsync, 1);
                46: begin
                    check("p46_vsync_idle", vsync, 0);
                    check("p46_strobes", {frame_start, line_start}, 2'b01);
                end
                73:  check("p73_pre_active", {de, x, rgb}, 0);
                74: begin
                    check("p74_de_first", {de, x, y}, {1'b1, 8'd0, 8'd0});
                    check("p74_rgb", rgb, RgbX0);
                end
                76:  check("p76_x2_rgb", {x, rgb}, {8'd2, RgbX2});
                78:  check("p78_x4_rgb", {x, rgb}, {8'd4, RgbX4});
                89: begin
                    check("p89_line_end", {de, x, y}, {1'b1, 8'd15, 8'd0});
                    check("p89_rgb", rgb, RgbX15);
                end
                90:  check("p90_front_porch", {de, x}, 0);
                158: check("p158_last_de", {de, x, y}, {1'b1, 8'd15, 8'd3});
                159: check("p159_after_last", {de, y}, 0);
                183: check("p183_frame_end", {hsync, vsync, line_start}, 3'b100);
                184: begin
                    check("p184_wrap_strobes", {frame_start, line_start}, 2'b11);
                    check("p184_wrap_sync", {hsync, vsync}, 2'b01);
                end
                default: ;
            endcase
        end
        check("frame_line_starts", n_ls, 8);
        check("frame_frame_starts", n_fs, 1);
        check("frame_hsync_active", n_hs, 24);
        check("frame_vsync_active", n_vs, 46);
        check("frame_de_cycles", n_de, 64);
        check("frame_blank_zero", n_blank_bad, 0);

        // Mid-line reset at (h=11, v=3) while de is high, with ce low.
        repeat (80) tick();
        check("pre_reset_pos", {de, x, y}, {1'b1, 8'd6, 8'd0});
        rst = 1'b1;
        ce  = 1'b0;
        tick();
        check_reset_state("midreset");
        rst = 1'b0;
        ce  = 1'b1;
        tick();
        check("restart_strobes", {frame_start, line_start}, 2'b11);
        check("restart_sync", {hsync, vsync, de}, 3'b010);
        tick();
        check("restart_p1", {frame_start, line_start}, 2'b00);

        // ce 1-of-4: outputs hold on ce=0 edges; a frame spans 184*4 clocks.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold_bad = 0; ls_rises = 0; fs_rise0 = -1; fs_rise1 = -1;
        prev = {hsync, vsync, de, x, y, line_start, frame_start, rgb};
        for (int c = 0; c < 740; c++) begin
            ce = (c % 4 == 0);
            tick();
            snap = {hsync, vsync, de, x, y, line_start, frame_start, rgb};
            if (!ce && snap != prev) hold_bad++;
            if (frame_start && !prev[24]) begin
                if (fs_rise0 < 0) fs_rise0 = c;
                else if (fs_rise1 < 0) fs_rise1 = c;
            end
            if (c < 736 && line_start && !prev[25]) ls_rises++;
            prev = snap;
        end
        check("ce_hold", hold_bad, 0);
        check("ce_first_frame_start", fs_rise0, 0);
        check("ce_frame_length", fs_rise1 - fs_rise0, 736);
        check("ce_line_starts", ls_rises, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
